// File: rtl/ssd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ssd_scan_ctrl -- time-multiplexed scan controller for a 4-digit
// seven-segment display sharing one external segment decoder.
//
// Digit values are written into shadow registers at any time. A frame of
// four digits is always shown from a consistent snapshot: shadow values are
// copied into the active registers only at a frame boundary or while idle.
//
// Parameter:
//   DIV           cycles each digit is shown (2..255)
// Ports:
//   clk_i         clock, all state updates on the rising edge
//   rst_i         synchronous active-high reset
//   scan_en_i     1 = scan the display, 0 = blank and idle
//   wr_en_i       shadow register write strobe
//   wr_addr_i     digit slot written (0..3)
//   wr_data_i     digit value written
//   dec_in_o      value fed to the shared decoder (combinational)
//   dec_seg_i     decoder result for dec_in_o
//   seg_o         registered segment pattern, active-low, 7'h7F = blank
//   dig_sel_o     registered one-hot digit enable, active-high
//   frame_done_o  one-cycle pulse on the last cycle of each frame
// Configuration:
//   SSD_SCAN_BLANK_EN  when defined, inserts one blank cycle between digits
// ---------------------------------------------------------------------------
module ssd_scan_ctrl #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scan_en_i,
  input  logic       wr_en_i,
  input  logic [1:0] wr_addr_i,
  input  logic [3:0] wr_data_i,
  output logic [3:0] dec_in_o,
  input  logic [6:0] dec_seg_i,
  output logic [6:0] seg_o,
  output logic [3:0] dig_sel_o,
  output logic       frame_done_o
);

  localparam logic [7:0] PRESC_LAST = 8'(DIV - 1);
  localparam logic [6:0] SEG_BLANK  = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW
`ifdef SSD_SCAN_BLANK_EN
    , ST_BLANK
`endif
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] presc_q, presc_d;
  logic [3:0] shadow_q [4];
  logic [3:0] shadow_d [4];
  logic [3:0] active_q [4];
  logic [3:0] active_d [4];
  logic       pending_q, pending_d;
  logic [6:0] seg_q, seg_d;
  logic [3:0] dig_sel_q, dig_sel_d;
  logic       frame_bnd;

  // The decoder always sees the committed value of the slot in focus.
  assign dec_in_o     = active_q[idx_q];
  assign seg_o        = seg_q;
  assign dig_sel_o    = dig_sel_q;
  // Pulse is combinational so a write in this same cycle joins the commit;
  // it is masked by reset because reset abandons the frame.
  assign frame_done_o = frame_bnd && !rst_i;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    presc_d   = presc_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    seg_d     = SEG_BLANK;
    dig_sel_d = 4'b0000;
    frame_bnd = 1'b0;

    if (wr_en_i) begin
      shadow_d[wr_addr_i] = wr_data_i;
      pending_d           = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        idx_d   = 2'd0;
        presc_d = 8'd0;
        if (scan_en_i) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (!scan_en_i) begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
          presc_d = 8'd0;
        end else begin
          seg_d     = dec_seg_i;
          dig_sel_d = 4'b0001 << idx_q;
          if (presc_q == PRESC_LAST) begin
            presc_d   = 8'd0;
            idx_d     = idx_q + 2'd1;
            frame_bnd = (idx_q == 2'd3);
`ifdef SSD_SCAN_BLANK_EN
            state_d   = ST_BLANK;
`endif
          end else begin
            presc_d = presc_q + 8'd1;
          end
        end
      end
`ifdef SSD_SCAN_BLANK_EN
      // idx already advanced on entry; outputs stay blank for this cycle.
      ST_BLANK: begin
        if (!scan_en_i) begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
          presc_d = 8'd0;
        end else begin
          state_d = ST_SHOW;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // pending_d already includes a write from this cycle, so that write is
    // carried into the commit and the flag ends cleared.
    if (pending_d && (frame_bnd || state_q == ST_IDLE)) begin
      active_d  = shadow_d;
      pending_d = 1'b0;
    end
  end

  // NOTE: non-blocking assignments keep every register sampling the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      presc_q   <= 8'd0;
      // NOTE: the digit storage is reset on purpose: after reset every slot
      // must read back as zero, so these arrays cannot be left uninitialised.
      shadow_q  <= '{default: 4'd0};
      active_q  <= '{default: 4'd0};
      pending_q <= 1'b0;
      seg_q     <= SEG_BLANK;
      dig_sel_q <= 4'b0000;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      presc_q   <= presc_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      dig_sel_q <= dig_sel_d;
    end
  end

endmodule
